// File: rtl/lzc_byte_gen_pkg.sv
// Shared types and constants for the LZC byte-stream stimulus generator.
package lzc_byte_gen_pkg;

  localparam int FRAME_W = 32;
  localparam int BYTE_W  = 8;
  localparam logic [5:0] MAX_Z = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Clamp a requested zero count to the frame width.
  function automatic logic [5:0] sat_z(input logic [5:0] z);
    return (z > MAX_Z) ? MAX_Z : z;
  endfunction

  // Byte i of a frame word, byte 0 being the most significant.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [FRAME_W-1:0] w,
                                                 input logic [1:0] i);
    logic [BYTE_W-1:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lzc_byte_gen_word_build.sv
// Builds the frame word with exactly z leading zeros and the mode-1 last byte index.
module lzc_word_build
  import lzc_byte_gen_pkg::*;
(
  input  logic [5:0]         z,
  input  logic [FRAME_W-1:0] tail,
  output logic [FRAME_W-1:0] word,
  output logic [1:0]         last_idx
);

  logic [FRAME_W-1:0] lead;
  logic [FRAME_W-1:0] below;

  // Shifting by 32 clears both masks, so z = 32 yields an all-zero word.
  always_comb begin
    lead     = 32'h8000_0000 >> z;
    below    = 32'h7FFF_FFFF >> z;
    word     = lead | (tail & below);
    // First nonzero byte sits at z/8; z >= 24 (including 32) caps at the last byte.
    last_idx = (z >= 6'd24) ? 2'd3 : z[4:3];
  end

endmodule

// File: rtl/lzc_byte_gen.sv
// Frame generator feeding a byte-serial leading-zero counter, MSB byte first.
module lzc_byte_gen
  import lzc_byte_gen_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [5:0]        ZCOUNT,
  input  logic              MODE_IN,
  input  logic [31:0]       TAIL,
  output logic              IVALID,
  output logic [BYTE_W-1:0] DATA,
  output logic              MODE,
  output logic [5:0]        EXP_ZEROS,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t             state;
  logic [FRAME_W-1:0] w_q;
  logic [1:0]         idx;
  logic [1:0]         last_q;
  logic [3:0]         gap_cnt;

  logic [5:0]         z_sat;
  logic [FRAME_W-1:0] w_new;
  logic [1:0]         m1_last;

  assign z_sat = sat_z(ZCOUNT);

  lzc_word_build u_build (
    .z        (z_sat),
    .tail     (TAIL),
    .word     (w_new),
    .last_idx (m1_last)
  );

  // Frame sequencer; the first byte is registered on the same edge that accepts START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      w_q       <= '0;
      idx       <= '0;
      last_q    <= '0;
      gap_cnt   <= '0;
      IVALID    <= 1'b0;
      DATA      <= '0;
      MODE      <= 1'b0;
      EXP_ZEROS <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state     <= ST_SEND;
            w_q       <= w_new;
            idx       <= 2'd0;
            last_q    <= MODE_IN ? m1_last : 2'd3;
            MODE      <= MODE_IN;
            EXP_ZEROS <= z_sat;
            IVALID    <= 1'b1;
            DATA      <= get_byte(w_new, 2'd0);
            BUSY      <= 1'b1;
          end
        end
        ST_SEND: begin
          if (idx == last_q) begin
            state   <= ST_GAP;
            IVALID  <= 1'b0;
            DATA    <= '0;
            DONE    <= 1'b1;
            gap_cnt <= '0;
          end else begin
            idx  <= idx + 2'd1;
            DATA <= get_byte(w_q, idx + 2'd1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_byte_gen.sv
// Directed self-checking bench for lzc_byte_gen.
module tb_lzc_byte_gen;

  localparam int GAP = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [5:0]  ZCOUNT;
  logic        MODE_IN;
  logic [31:0] TAIL;
  logic        IVALID;
  logic [7:0]  DATA;
  logic        MODE;
  logic [5:0]  EXP_ZEROS;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  lzc_byte_gen #(.GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ZCOUNT(ZCOUNT), .MODE_IN(MODE_IN),
    .TAIL(TAIL), .IVALID(IVALID), .DATA(DATA), .MODE(MODE),
    .EXP_ZEROS(EXP_ZEROS), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leading zeros of the n received bytes, as an LZC receiver would count them.
  function automatic int clz_bytes(input logic [31:0] cap, input int n);
    logic [31:0] w;
    w = cap << (8 * (4 - n));
    for (int i = 31; i >= 32 - 8 * n; i--)
      if (w[i]) return 31 - i;
    return 8 * n;
  endfunction

  // Request one frame from IDLE; returns while the first byte is on DATA.
  task automatic start_frame(input logic [5:0] z, input logic m, input logic [31:0] t);
    ZCOUNT = z; MODE_IN = m; TAIL = t; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Collect consecutive valid bytes; stops on the first non-valid cycle.
  task automatic capture(output logic [31:0] cap, output int n, output logic done_seen);
    cap = '0; n = 0; done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (IVALID) begin
        cap = {cap[23:0], DATA};
        n++;
        tick();
      end else begin
        done_seen = DONE;
        break;
      end
    end
  endtask

  task automatic wait_idle(output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!BUSY) begin timed_out = 1'b0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic to;
    RST = 1'b1; START = 1'b1; ZCOUNT = 6'd0; MODE_IN = 1'b1; TAIL = 32'hFFFF_FFFF;
    tick(); tick();
    total++; if (IVALID !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b exp=0", IVALID); end
    total++; if (DATA !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", DATA); end
    total++; if (MODE !== 1'b0) begin bad++; $display("FAIL rst_mode got=%b exp=0", MODE); end
    total++; if (EXP_ZEROS !== 6'd0) begin bad++; $display("FAIL rst_exp got=%0d exp=0", EXP_ZEROS); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", DONE); end
    // START held across reset release is taken at the first non-reset edge.
    RST = 1'b0; MODE_IN = 1'b0; TAIL = 32'h0;
    tick();
    START = 1'b0;
    total++; if ({IVALID, DATA} !== {1'b1, 8'h80}) begin bad++; $display("FAIL rst_first_start got=%b/%h exp=1/80", IVALID, DATA); end
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL rst_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_z0_mode0();
    logic [31:0] cap; int n; logic dn; logic to;
    start_frame(6'd0, 1'b0, 32'h0);
    total++; if (EXP_ZEROS !== 6'd0) begin bad++; $display("FAIL z0_exp got=%0d exp=0", EXP_ZEROS); end
    total++; if (MODE !== 1'b0) begin bad++; $display("FAIL z0_mode got=%b exp=0", MODE); end
    capture(cap, n, dn);
    total++; if (cap !== 32'h8000_0000) begin bad++; $display("FAIL z0_bytes got=%h exp=80000000", cap); end
    total++; if (n !== 4) begin bad++; $display("FAIL z0_count got=%0d exp=4", n); end
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL z0_done got=%b exp=1", dn); end
    total++; if (DATA !== 8'h00) begin bad++; $display("FAIL z0_gap_data got=%h exp=00", DATA); end
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL z0_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_z11_mode1();
    logic [31:0] cap; int n; logic dn; logic to;
    start_frame(6'd11, 1'b1, 32'h0);
    capture(cap, n, dn);
    total++; if (cap !== 32'h0000_0010) begin bad++; $display("FAIL z11_bytes got=%h exp=00000010", cap); end
    total++; if (n !== 2) begin bad++; $display("FAIL z11_count got=%0d exp=2", n); end
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL z11_done got=%b exp=1", dn); end
    total++; if (EXP_ZEROS !== 6'd11) begin bad++; $display("FAIL z11_exp got=%0d exp=11", EXP_ZEROS); end
    total++; if (MODE !== 1'b1) begin bad++; $display("FAIL z11_mode got=%b exp=1", MODE); end
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL z11_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_z3_tail();
    logic [31:0] cap; int n; logic dn; logic to;
    start_frame(6'd3, 1'b1, 32'hFFFF_FFFF);
    capture(cap, n, dn);
    total++; if (cap !== 32'h0000_001F) begin bad++; $display("FAIL z3m1_bytes got=%h exp=0000001f", cap); end
    total++; if (n !== 1) begin bad++; $display("FAIL z3m1_count got=%0d exp=1", n); end
    wait_idle(to);
    start_frame(6'd3, 1'b0, 32'hFFFF_FFFF);
    capture(cap, n, dn);
    total++; if (cap !== 32'h1FFF_FFFF) begin bad++; $display("FAIL z3m0_bytes got=%h exp=1fffffff", cap); end
    total++; if (n !== 4) begin bad++; $display("FAIL z3m0_count got=%0d exp=4", n); end
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL z3_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_sat_gap_ignore();
    logic [31:0] cap; int n; logic dn; logic seen; logic to;
    start_frame(6'd40, 1'b1, 32'h1234_5678);
    capture(cap, n, dn);
    total++; if (cap !== 32'h0) begin bad++; $display("FAIL sat_bytes got=%h exp=00000000", cap); end
    total++; if (n !== 4) begin bad++; $display("FAIL sat_count got=%0d exp=4", n); end
    total++; if (EXP_ZEROS !== 6'd32) begin bad++; $display("FAIL sat_exp got=%0d exp=32", EXP_ZEROS); end
    // START across both GAP cycles, including the last one, must be dropped.
    START = 1'b1;
    tick(); tick();
    START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (IVALID) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL gap_start_ignored got=frame exp=none"); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL gap_busy got=%b exp=0", BUSY); end
    wait_idle(to);
  endtask

  task automatic test_reset_mid_send();
    logic [31:0] cap; int n; logic dn; logic to;
    start_frame(6'd31, 1'b0, 32'h0);
    tick();
    RST = 1'b1;
    tick();
    total++; if (IVALID !== 1'b0) begin bad++; $display("FAIL midrst_ivalid got=%b exp=0", IVALID); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", DONE); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", BUSY); end
    RST = 1'b0;
    tick();
    total++; if ({IVALID, DONE} !== 2'b00) begin bad++; $display("FAIL midrst_after got=%b%b exp=00", IVALID, DONE); end
    start_frame(6'd31, 1'b0, 32'h0);
    capture(cap, n, dn);
    total++; if (cap !== 32'h0000_0001) begin bad++; $display("FAIL midrst_frame got=%h exp=00000001", cap); end
    total++; if (n !== 4) begin bad++; $display("FAIL midrst_count got=%0d exp=4", n); end
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL midrst_done2 got=%b exp=1", dn); end
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL midrst_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap; int n; logic dn; int g; logic to;
    ZCOUNT = 6'd13; MODE_IN = 1'b0; TAIL = 32'hAAAA_AAAA; START = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      capture(cap, n, dn);
      total++; if (cap !== 32'h0006_AAAA) begin bad++; $display("FAIL b2b_bytes f=%0d got=%h exp=0006aaaa", f, cap); end
      total++; if (clz_bytes(cap, n) !== int'(EXP_ZEROS)) begin bad++; $display("FAIL b2b_lzc f=%0d got=%0d exp=%0d", f, clz_bytes(cap, n), EXP_ZEROS); end
      total++; if (EXP_ZEROS !== 6'd13) begin bad++; $display("FAIL b2b_exp f=%0d got=%0d exp=13", f, EXP_ZEROS); end
      if (f == 2) START = 1'b0;
      else begin
        g = 0;
        while (!IVALID && g < 20) begin g++; tick(); end
        total++; if (g !== GAP + 1) begin bad++; $display("FAIL b2b_gap f=%0d got=%0d exp=%0d", f, g, GAP + 1); end
      end
    end
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL b2b_idle_timeout got=busy exp=idle"); end
  endtask

  initial begin
    test_reset();
    test_z0_mode0();
    test_z11_mode1();
    test_z3_tail();
    test_sat_gap_ignore();
    test_reset_mid_send();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lzc_byte_gen.md
LZC_BYTE_GEN -- requirements
Module: lzc_byte_gen

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced between frames (range 1..15).
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port START  input  1  request a frame; sampled only in IDLE.
REQ-005 SHALL have port ZCOUNT  input  6  requested leading-zero count of the 32-bit frame.
REQ-006 SHALL have port MODE_IN  input  1  frame mode: 0 = fixed 4 bytes, 1 = stop after first nonzero byte.
REQ-007 SHALL have port TAIL  input  32  fill bits placed below the leading one.
REQ-008 SHALL have port IVALID  output  1  byte-valid strobe toward an LZC receiver.
REQ-009 SHALL have port DATA  output  8  frame byte, most significant byte first.
REQ-010 SHALL have port MODE  output  1  latched frame mode, held constant for the whole frame.
REQ-011 SHALL have port EXP_ZEROS  output  6  expected zero count of the frame in flight, for the checker.
REQ-012 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse after the last byte of a frame.

Function
REQ-014 SHALL implement three states: IDLE, SEND, GAP.
REQ-015 IDLE with START=1 SHALL, at that edge, go to SEND and latch Z = min(ZCOUNT, 32), MODE_IN and TAIL.
REQ-016 The frame word SHALL be W = 0 if Z = 32; otherwise bit (31-Z) = 1, bits above it = 0, bits below it = the same bits of TAIL.
REQ-017 Timing: START sampled at edge t SHALL give first byte W[31:24] with IVALID=1 from edge t to edge t+1.
REQ-018 Bytes SHALL follow on consecutive cycles with no IVALID bubbles: W[31:24], W[23:16], W[15:8], W[7:0].
REQ-019 Byte count, mode 0: SHALL send exactly 4 bytes.
REQ-020 Byte count, mode 1: SHALL send bytes through and including the first nonzero byte, i.e. floor(Z/8)+1 bytes, capped at 4.
REQ-021 Byte count, mode 1, Z = 32: SHALL send 4 zero bytes.
REQ-022 SHALL use a 2-bit byte index, cleared on frame start; it never wraps within a frame.
REQ-023 After the last byte, SHALL enter GAP with IVALID=0, DATA=0 and DONE=1 for one cycle.
REQ-024 GAP SHALL last GAP_CYCLES cycles on a 4-bit counter, then return to IDLE.
REQ-025 START SHALL be ignored in SEND and GAP; it is not queued.
REQ-026 START asserted in the last GAP cycle SHALL be ignored; it is accepted only when sampled in IDLE.
REQ-027 DATA SHALL be 0 whenever IVALID=0.
REQ-028 MODE and EXP_ZEROS SHALL hold the latched values from frame start through the end of GAP.
REQ-029 ZCOUNT values 33..63 SHALL saturate to 32 for both W and EXP_ZEROS.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 RST=1 at an edge SHALL force IDLE and clear IVALID, DATA, MODE, EXP_ZEROS, BUSY, DONE and all counters to 0, overriding START.
REQ-032 RST asserted mid-SEND SHALL drop IVALID at that edge, discard the partial frame and produce no DONE pulse.
REQ-033 The first START honoured after reset SHALL be sampled at the first edge with RST=0.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE, SEND, GAP), the frame width 32, the byte width 8 and the maximum zero count 32.
REQ-035 One sub-module, lzc_word_build, SHALL be combinational and map (Z, TAIL) to W and the mode-1 byte count.

Verification
REQ-036 Z=0, TAIL=0, mode 0 -> DATA 80,00,00,00 on 4 consecutive cycles, then DONE; EXP_ZEROS=0.
REQ-037 Z=11, TAIL=0, mode 1 -> DATA 00,10 (2 bytes), IVALID low on the 3rd cycle; EXP_ZEROS=11.
REQ-038 Z=3, TAIL=FFFFFFFF, mode 1 -> single byte 1F; mode 0 -> 1F,FF,FF,FF.
REQ-039 ZCOUNT=40, mode 1 -> 4 zero bytes, EXP_ZEROS=32; a START pulse during GAP produces no frame.
REQ-040 RST raised after the 2nd byte of a Z=31 mode 0 frame -> IVALID=0 at the next edge, no DONE; a new START gives a clean frame 00,00,00,01.
REQ-041 Back-to-back frames with START held high -> exactly GAP_CYCLES+1 non-valid cycles between frames, and every frame decoded by LZC matches EXP_ZEROS.
